tristate_bus_arbiter: RTL
=========================

Name: tristate_bus_arbiter

Overview:
- Parametrised successor to the single-gate notif0/notif1 tristate buffers.
- Arbitrates N requesters onto one shared W-bit tristate bus with registered output enable.
- Each channel has a per-channel inverting (notif-style) option.
- Enforces a turnaround gap of released-bus cycles between owners, and caps ownership length so no channel starves the others.

Parameters:
- N, 4, number of requesting channels (1..16)
- W, 8, bus/data width in bits
- INVERT_MASK, {N{1'b0}}, bit i=1 drives ~data of channel i (notif behaviour); 0 drives data unchanged
- TURN_CYCLES, 1, released-bus cycles between owners (1..15; 0 is illegal)
- MAX_HOLD, 8, max consecutive DRIVE cycles per grant (1..255)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  per-channel bus request, level-sensitive
- data  input  N*W  channel i data at bits [i*W +: W]
- bus  output  W  tristate bus; 'z when oe=0
- oe  output  1  registered bus output enable
- grant  output  N  one-hot current owner, all-zero when bus released
- owner  output  max(1,$clog2(N))  binary index of last/current owner
- turn  output  1  high during TURN state

Behaviour:
- One clock; reset is synchronous and active-high. rst is sampled on the rising edge of clk.
- Reset values: state=IDLE, oe=0, bus='z, grant=0, owner=0, turn=0, rr pointer=0, hold counter=0. Reset mid-DRIVE releases bus at that same edge; no TURN is inserted.
- FSM states: IDLE, DRIVE, TURN.
- IDLE:
  - If req!=0, pick a winner by round-robin, searching from index ptr upward with wrap.
  - Next edge: DRIVE, grant=onehot(winner), owner=winner, oe=1, bus_q=data[winner]^{W{INVERT_MASK[winner]}}, hold=1.
  - If req=0, remain IDLE with the bus released.
- DRIVE:
  - Each edge while req[owner]=1 and hold<MAX_HOLD: reload bus_q from the owner's data (with inversion), hold++.
  - The bus therefore shows data sampled at the previous edge (1-cycle latency).
  - If req[owner]=0 or hold==MAX_HOLD: next edge → TURN, with oe=0, grant=0, bus='z, turn=1, ptr=(owner+1) mod N, turn counter=TURN_CYCLES-1. owner is retained.
- TURN:
  - bus='z, oe=0.
  - When the turn counter is 0 and req!=0: arbitrate exactly as in IDLE and enter DRIVE on that edge (turn=0).
  - When the turn counter is 0 and req=0: go to IDLE.
  - Otherwise decrement the counter.
- Requests arriving during TURN are not granted until TURN completes. A channel dropping req during TURN is not granted.
- Simultaneous requests: round-robin order from ptr. A single requester re-requesting after MAX_HOLD is re-granted after TURN.
- bus is never driven in the same cycle that grant changes owner. oe and grant[owner] are always equal.
- Hold counter width is $clog2(MAX_HOLD+1). Turn counter is 4 bits.
- Data changes on an unowned channel have no effect on bus.

Optional Feature:
- Macro: TRISTATE_BUS_KEEPER_EN.
- Defined: while oe=0, bus holds the last driven value (bus keeper) instead of 'z. Reset still forces bus='z until the first grant.
- Undefined: bus='z whenever oe=0.

Test Plan:
- Reset: N=4, W=8, assert rst 2 cycles → bus=8'hzz, oe=0, grant=4'b0000, owner=0, turn=0.
- Inversion: INVERT_MASK=4'b0001, req=4'b0001, data0=8'hA5 → next edge grant=0001, oe=1, bus=8'h5A. Change data0=8'h0F → one edge later bus=8'hF0.
- Handoff: ch0 owning, req changes 0001→0100, data2=8'h3C, TURN_CYCLES=2 → 1 cycle DRIVE-tail, then 2 cycles bus=z/turn=1, then grant=0100, bus=8'h3C.
- Fairness: MAX_HOLD=3, TURN_CYCLES=1, req=4'b1111 held → grant sequence 0001,0010,0100,1000,0001. Each owner holds 3 cycles; each handoff has 1 z cycle.
- Reset mid-drive: rst in 2nd DRIVE cycle of ch1 → same edge oe=0, grant=0, bus=z, state IDLE. After release with req=0010 → re-grant of ch1 after 1 edge.
- Keeper (TRISTATE_BUS_KEEPER_EN): ch3 drives 8'h77 then releases → during TURN/IDLE bus=8'h77, oe=0. Without the macro → bus=8'hzz.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin arbiter driving N channels onto one shared W-bit tristate bus.
// Define TRISTATE_BUS_KEEPER_EN to make the bus hold its last driven value while released.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | bus released, no owner, waiting for any request
// S_DRIVE | owner_q drives the bus with its (optionally inverted) data
// S_TURN  | bus released for TURN_CYCLES cycles between owners
module tristate_bus_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter logic [N-1:0] INVERT_MASK = '0,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD = 8,
  localparam int OW = (N > 1) ? $clog2(N) : 1,
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data,
  output logic [W-1:0]    bus,
  output logic            oe,
  output logic [N-1:0]    grant,
  output logic [OW-1:0]   owner,
  output logic            turn
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, ptr_q, nxt_ptr;
  logic [HW-1:0] hold_q;
  logic [3:0]    turn_cnt_q;
  logic [W-1:0]  bus_q, win_data, own_data;
  logic [OW-1:0] win, arb_idx;
  logic          win_vld, hold_max, turn_done, drive_keep, grant_now;

  // Round-robin search starting at ptr_q, wrapping past N-1.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    arb_idx = '0;
    for (int k = 0; k < N; k++) begin
      arb_idx = OW'((int'(ptr_q) + k) % N);
      if (!win_vld && req[arb_idx]) begin
        win     = arb_idx;
        win_vld = 1'b1;
      end
    end
  end

  assign win_data   = data[win*W +: W] ^ {W{INVERT_MASK[win]}};
  assign own_data   = data[owner_q*W +: W] ^ {W{INVERT_MASK[owner_q]}};
  assign hold_max   = (hold_q == HW'(MAX_HOLD));
  assign turn_done  = (turn_cnt_q == 4'd0);
  assign drive_keep = (state_q == S_DRIVE) && req[owner_q] && !hold_max;
  assign grant_now  = win_vld && ((state_q == S_IDLE) || ((state_q == S_TURN) && turn_done));
  assign nxt_ptr    = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_vld) state_d = S_DRIVE;
      S_DRIVE: if (!drive_keep) state_d = S_TURN;
      S_TURN:  if (turn_done) state_d = win_vld ? S_DRIVE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oe    = 1'b0;
    turn  = 1'b0;
    grant = '0;
    case (state_q)
      S_DRIVE: begin
        oe             = 1'b1;
        grant[owner_q] = 1'b1;
      end
      S_TURN:  turn = 1'b1;
      default: ;
    endcase
  end

  // bus_q is only reloaded while owned, so it doubles as the keeper value after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      turn_cnt_q <= '0;
      bus_q      <= '0;
    end else if (grant_now) begin
      owner_q <= win;
      bus_q   <= win_data;
      hold_q  <= HW'(1);
    end else if (drive_keep) begin
      bus_q  <= own_data;
      hold_q <= hold_q + HW'(1);
    end else if (state_q == S_DRIVE) begin
      ptr_q      <= nxt_ptr;
      turn_cnt_q <= 4'(TURN_CYCLES - 1);
    end else if ((state_q == S_TURN) && !turn_done) begin
      turn_cnt_q <= turn_cnt_q - 4'd1;
    end
  end

  assign owner = owner_q;

`ifdef TRISTATE_BUS_KEEPER_EN
  logic kept_q;

  always_ff @(posedge clk) begin
    if (rst)            kept_q <= 1'b0;
    else if (grant_now) kept_q <= 1'b1;
  end

  assign bus = (oe || kept_q) ? bus_q : {W{1'bz}};
`else
  assign bus = oe ? bus_q : {W{1'bz}};
`endif

endmodule
